// File: rtl/spike_rate_decoder.sv
//----------------------------------------------------------------------------
// Module   : spike_rate_decoder
// Function : Converts a neuron spike bus into a windowed spike rate (valid/
//            ready output with sticky overrun) and the last inter-spike interval.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module spike_rate_decoder #(
  parameter int WINDOW = 256,
  parameter int RATE_W = 8,
  parameter int ISI_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [7:0]        spike_in,
  input  logic              rate_ready,
  output logic [RATE_W-1:0] rate_out,
  output logic              rate_valid,
  output logic              overrun,
  output logic [ISI_W-1:0]  isi_out,
  output logic              isi_valid,
  output logic              spike_event
);

  localparam int                c_win_w    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW - 1);
  localparam logic [RATE_W-1:0] c_rate_max = '1;
  localparam logic [ISI_W-1:0]  c_isi_max  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_s_q;
  logic                r_s_d;
  logic                r_en_d;
  logic [c_win_w-1:0]  r_win_cnt;
  logic [RATE_W-1:0]   r_spk_cnt;
  logic [ISI_W-1:0]    r_isi_cnt;
  logic [RATE_W-1:0]   r_rate;
  logic                r_rate_valid;
  logic                r_overrun;
  logic [ISI_W-1:0]    r_isi;
  logic                r_isi_valid;

  logic                w_event;
  logic                w_active;
  logic                w_close;
  logic [RATE_W-1:0]   w_cnt_inc;

  assign w_event   = r_s_q & ~r_s_d;
  assign w_active  = en & (r_state != S_IDLE);
  assign w_close   = w_active & (r_win_cnt == c_win_last);
  // Count including this cycle's event, held at full scale.
  assign w_cnt_inc = (w_event && (r_spk_cnt != c_rate_max)) ?
                     r_spk_cnt + RATE_W'(1) : r_spk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_s_q        <= 1'b0;
      r_s_d        <= 1'b0;
      r_en_d       <= 1'b0;
      r_win_cnt    <= '0;
      r_spk_cnt    <= '0;
      r_isi_cnt    <= '0;
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_isi        <= '0;
      r_isi_valid  <= 1'b0;
    end else begin
      r_s_q       <= |spike_in;
      r_s_d       <= r_s_q;
      r_en_d      <= en;
      r_isi_valid <= 1'b0;

      if (!en) begin
        r_state   <= S_IDLE;
        r_win_cnt <= '0;
        r_spk_cnt <= '0;
        r_isi_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_ARM;
          S_ARM: begin
            if (w_event) begin
              r_state   <= S_TRACK;
              r_isi_cnt <= ISI_W'(1);
            end
          end
          S_TRACK: begin
            if (w_event) begin
              r_isi       <= r_isi_cnt;
              r_isi_valid <= 1'b1;
              r_isi_cnt   <= ISI_W'(1);
            end else if (r_isi_cnt != c_isi_max) begin
              r_isi_cnt <= r_isi_cnt + ISI_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase

        if (r_state != S_IDLE) begin
          if (w_close) begin
            r_win_cnt <= '0;
            r_spk_cnt <= '0;
          end else begin
            r_win_cnt <= r_win_cnt + c_win_w'(1);
            r_spk_cnt <= w_cnt_inc;
          end
        end
      end

      // A closing window always wins over a transfer on the same edge.
      if (w_close) begin
        r_rate       <= w_cnt_inc;
        r_rate_valid <= 1'b1;
        if (r_rate_valid && !rate_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (r_rate_valid && rate_ready) begin
        r_rate_valid <= 1'b0;
      end

      if (en && !r_en_d) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign rate_out    = r_rate;
  assign rate_valid  = r_rate_valid;
  assign overrun     = r_overrun;
  assign isi_out     = r_isi;
  assign isi_valid   = r_isi_valid;
  assign spike_event = w_event;

endmodule

`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
//----------------------------------------------------------------------------
// Module   : tb_spike_rate_decoder
// Function : Self-checking bench for spike_rate_decoder (WINDOW=16 and 1024).
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_spike_rate_decoder;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       en         = 1'b0;
  logic       rate_ready = 1'b0;
  logic [7:0] spike_in   = 8'h00;

  logic [7:0]  d_rate [2];
  logic        d_rv   [2];
  logic        d_ov   [2];
  logic [15:0] d_isi  [2];
  logic        d_iv   [2];
  logic        d_ev   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW(16), .RATE_W(8), .ISI_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in), .rate_ready(rate_ready),
    .rate_out(d_rate[0]), .rate_valid(d_rv[0]), .overrun(d_ov[0]),
    .isi_out(d_isi[0]), .isi_valid(d_iv[0]), .spike_event(d_ev[0]));

  spike_rate_decoder #(.WINDOW(1024), .RATE_W(8), .ISI_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in), .rate_ready(rate_ready),
    .rate_out(d_rate[1]), .rate_valid(d_rv[1]), .overrun(d_ov[1]),
    .isi_out(d_isi[1]), .isi_valid(d_iv[1]), .spike_event(d_ev[1]));

  // Reference model: event timestamps, window tick counts and plain arithmetic.
  bit     m_sq, m_sd, m_en_d;
  longint m_t;
  bit     m_on    [2];
  int     m_ticks [2];
  int     m_cnt   [2];
  bit     m_have  [2];
  longint m_last  [2];
  int     m_rate  [2];
  bit     m_valid [2];
  bit     m_ov    [2];
  int     m_isi   [2];
  bit     m_iv    [2];
  bit     mdl_ev, mdl_close;

  function automatic int win_of(input int i);
    return (i == 0) ? 16 : 1024;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sq = 0; m_sd = 0; m_en_d = 0; m_t = 0;
      for (int i = 0; i < 2; i++) begin
        m_on[i] = 0; m_ticks[i] = 0; m_cnt[i] = 0; m_have[i] = 0; m_last[i] = 0;
        m_rate[i] = 0; m_valid[i] = 0; m_ov[i] = 0; m_isi[i] = 0; m_iv[i] = 0;
      end
    end else begin
      mdl_ev = m_sq && !m_sd;
      m_t++;
      for (int i = 0; i < 2; i++) begin
        mdl_close = 0;
        m_iv[i]   = 0;
        if (!en) begin
          m_on[i] = 0; m_ticks[i] = 0; m_cnt[i] = 0; m_have[i] = 0;
        end else begin
          if (m_on[i]) begin
            if (mdl_ev) begin
              m_cnt[i]++;
              if (m_have[i]) begin
                m_isi[i] = ((m_t - m_last[i]) > 65535) ? 65535 : int'(m_t - m_last[i]);
                m_iv[i]  = 1;
              end
              m_have[i] = 1;
              m_last[i] = m_t;
            end
            mdl_close = (m_ticks[i] % win_of(i)) == (win_of(i) - 1);
            m_ticks[i]++;
            if (mdl_close) begin
              m_rate[i] = (m_cnt[i] > 255) ? 255 : m_cnt[i];
              m_cnt[i]  = 0;
            end
          end
          m_on[i] = 1;
        end
        if (mdl_close) begin
          if (m_valid[i] && !rate_ready) m_ov[i] = 1;
          m_valid[i] = 1;
        end else if (m_valid[i] && rate_ready) begin
          m_valid[i] = 0;
        end
        if (en && !m_en_d) m_ov[i] = 0;
      end
      m_sd   = m_sq;
      m_sq   = (spike_in != 8'h00);
      m_en_d = en;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int elapsed;
    rst_n = 0; en = 0; spike_in = 0; rate_ready = 0;
    tick(3);
    rst_n = 1;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({d_rate[i], d_rv[i], d_ov[i], d_isi[i], d_iv[i], d_ev[i]} !== 36'd0) begin
        n_fail++;
        $display("FAIL reset_init dut%0d: outputs %h, required 0", i,
                 {d_rate[i], d_rv[i], d_ov[i], d_isi[i], d_iv[i], d_ev[i]});
      end
    end
    en = 1; rate_ready = 1;
    for (int c = 0; c < 10; c++) begin
      spike_in = (c % 3 == 0) ? 8'h5A : 8'h00;
      tick(1);
    end
    spike_in = 8'hFF;
    #2 rst_n = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({d_rate[i], d_rv[i], d_ov[i], d_isi[i], d_iv[i], d_ev[i]} !== 36'd0) begin
        n_fail++;
        $display("FAIL reset_async dut%0d: outputs %h, required 0", i,
                 {d_rate[i], d_rv[i], d_ov[i], d_isi[i], d_iv[i], d_ev[i]});
      end
    end
    tick(1);
    rst_n = 1; spike_in = 0;
    elapsed = 0;
    while (!d_rv[0] && elapsed < 40) begin
      tick(1);
      elapsed++;
    end
    // One edge leaves IDLE, then WINDOW edges fill the first window.
    n_checks++;
    if (elapsed != 17) begin
      n_fail++;
      $display("FAIL reset_first_rate: valid after %0d cycles, required 17", elapsed);
    end
    n_checks++;
    if (d_rate[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_first_value: rate %0d, required 0", d_rate[0]);
    end
  endtask

  task automatic test_rate_isi();
    int n_iv, n_rv;
    en = 0; rate_ready = 1; spike_in = 0;
    tick(2);
    en = 1; n_iv = 0; n_rv = 0;
    for (int c = 0; c < 64; c++) begin
      spike_in = (c % 4 == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      tick(1);
      if (d_iv[0]) begin
        n_iv++;
        n_checks++;
        if (d_isi[0] !== 16'd4) begin
          n_fail++;
          $display("FAIL isi_value: isi %0d, required 4", d_isi[0]);
        end
      end
      if (d_rv[0]) begin
        n_rv++;
        n_checks++;
        if (d_rate[0] !== 8'd4) begin
          n_fail++;
          $display("FAIL rate_value: rate %0d, required 4", d_rate[0]);
        end
      end
    end
    spike_in = 0;
    n_checks++;
    if (n_rv != 3) begin
      n_fail++;
      $display("FAIL rate_count: %0d results, required 3", n_rv);
    end
    n_checks++;
    if (n_iv != 15) begin
      n_fail++;
      $display("FAIL isi_pulses: %0d pulses, required 15", n_iv);
    end
  endtask

  task automatic test_held_level();
    int n_ev;
    en = 0; rate_ready = 1; spike_in = 0;
    tick(2);
    en = 1; n_ev = 0;
    for (int c = 0; c < 17; c++) begin
      spike_in = (c < 10) ? 8'h01 : 8'h00;
      tick(1);
      if (d_ev[0]) n_ev++;
    end
    n_checks++;
    if (n_ev != 1) begin
      n_fail++;
      $display("FAIL held_events: %0d events, required 1", n_ev);
    end
    n_checks++;
    if (d_rv[0] !== 1'b1 || d_rate[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL held_rate: valid %b rate %0d, required 1 and 1", d_rv[0], d_rate[0]);
    end
  endtask

  task automatic test_overrun();
    en = 0; rate_ready = 1; spike_in = 0;
    tick(2);
    rate_ready = 0; en = 1;
    for (int c = 0; c <= 32; c++) begin
      spike_in = (c inside {1, 5, 9, 17, 19, 21, 23, 25}) ? 8'h80 : 8'h00;
      tick(1);
      if (c == 16) begin
        n_checks++;
        if (d_rate[0] !== 8'd3 || d_rv[0] !== 1'b1 || d_ov[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL overrun_first: rate %0d valid %b ovr %b, required 3 1 0",
                   d_rate[0], d_rv[0], d_ov[0]);
        end
      end
    end
    n_checks++;
    if (d_rate[0] !== 8'd5 || d_rv[0] !== 1'b1 || d_ov[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_second: rate %0d valid %b ovr %b, required 5 1 1",
               d_rate[0], d_rv[0], d_ov[0]);
    end
    rate_ready = 1;
    tick(1);
    n_checks++;
    if (d_rv[0] !== 1'b0 || d_ov[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_consume: valid %b ovr %b, required 0 1", d_rv[0], d_ov[0]);
    end
    en = 0;
    tick(1);
    en = 1;
    tick(1);
    n_checks++;
    if (d_ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: ovr %b, required 0", d_ov[0]);
    end
  endtask

  task automatic test_saturation();
    int  elapsed;
    bit  found;
    en = 0; rate_ready = 1; spike_in = 0;
    tick(2);
    en = 1; elapsed = 0;
    while (!d_rv[1] && elapsed < 1100) begin
      spike_in = (elapsed % 2 == 0) ? 8'h33 : 8'h00;
      tick(1);
      elapsed++;
    end
    n_checks++;
    if (d_rv[1] !== 1'b1 || d_rate[1] !== 8'd255) begin
      n_fail++;
      $display("FAIL rate_saturate: valid %b rate %0d, required 1 255", d_rv[1], d_rate[1]);
    end
    spike_in = 0;
    tick(3);
    spike_in = 8'h01;
    tick(1);
    spike_in = 0;
    tick(70000);
    spike_in = 8'h02;
    tick(1);
    spike_in = 0;
    found = 0;
    for (int c = 0; c < 5 && !found; c++) begin
      tick(1);
      if (d_iv[1]) found = 1;
    end
    n_checks++;
    if (!found || d_isi[1] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL isi_saturate: pulse %b isi %h, required 1 FFFF", found, d_isi[1]);
    end
  endtask

  task automatic test_simultaneous();
    bit saw;
    en = 0; rate_ready = 1; spike_in = 0;
    tick(2);
    rate_ready = 0; en = 1;
    for (int c = 0; c <= 32; c++) begin
      spike_in   = (c inside {15, 20, 24}) ? 8'h10 : 8'h00;
      rate_ready = (c == 32);
      tick(1);
      if (c == 16) begin
        n_checks++;
        if (d_rate[0] !== 8'd1 || d_rv[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL close_spike: rate %0d valid %b, required 1 1", d_rate[0], d_rv[0]);
        end
      end
    end
    n_checks++;
    if (d_rate[0] !== 8'd2 || d_rv[0] !== 1'b1 || d_ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_at_close: rate %0d valid %b ovr %b, required 2 1 0",
               d_rate[0], d_rv[0], d_ov[0]);
    end
    tick(1);
    n_checks++;
    if (d_rv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_close: valid %b, required 0", d_rv[0]);
    end
    en = 0;
    tick(2);
    rate_ready = 0; en = 1; saw = 0;
    for (int c = 0; c < 38; c++) begin
      if (c == 8) en = 0;
      spike_in = ($urandom_range(0, 2) == 0) ? 8'h44 : 8'h00;
      tick(1);
      if (d_rv[0]) saw = 1;
    end
    spike_in = 0;
    n_checks++;
    if (saw) begin
      n_fail++;
      $display("FAIL partial_window: valid seen %b, required 0", saw);
    end
  endtask

  task automatic test_random();
    bit ev_exp;
    rate_ready = 0; en = 0; spike_in = 0;
    tick(2);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (en) begin
        if ($urandom_range(0, 99) < 1) en = 0;
      end else if ($urandom_range(0, 99) < 20) begin
        en = 1;
      end
      spike_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      rate_ready = ($urandom_range(0, 2) != 0);
      tick(1);
      if (cyc == 2000) begin
        #2 rst_n = 0;
        #1 rst_n = 1;
      end
      ev_exp = m_sq && !m_sd;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (d_rate[i] !== m_rate[i][7:0] || d_rv[i] !== m_valid[i] || d_ov[i] !== m_ov[i] ||
            d_isi[i] !== m_isi[i][15:0] || d_iv[i] !== m_iv[i] || d_ev[i] !== ev_exp) begin
          n_fail++;
          $display("FAIL random dut%0d cyc %0d: got/req rate %0d/%0d valid %b/%b ovr %b/%b isi %0d/%0d isiv %b/%b ev %b/%b",
                   i, cyc, d_rate[i], m_rate[i], d_rv[i], m_valid[i], d_ov[i], m_ov[i],
                   d_isi[i], m_isi[i], d_iv[i], m_iv[i], d_ev[i], ev_exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rate_isi();
    test_held_level();
    test_overrun();
    test_saturation();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
